// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between two word sources, the arbiter and the FIFO write port.
// The arbiter takes the slave view; the sources/FIFO side takes the master view.
interface fifo_wr_arbiter_if #(
    parameter int DW = 8
);
    logic          req0;
    logic [DW-1:0] data0;
    logic          ack0;
    logic          req1;
    logic [DW-1:0] data1;
    logic          ack1;
    logic          wrfull;
    logic          wrreq;
    logic [DW-1:0] data;
    logic [1:0]    grant;
    logic          busy;

    modport slave (
        input  req0, data0, req1, data1, wrfull,
        output ack0, ack1, wrreq, data, grant, busy
    );

    modport master (
        output req0, data0, req1, data1, wrfull,
        input  ack0, ack1, wrreq, data, grant, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between two sources.
// Writes are combinational from state and inputs, so wrfull is honoured with zero latency.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no owner; picks next owner (ptr breaks ties), never writes
//   ST_BURST | owner in grant writes up to BURST words, stalls on wrfull
module fifo_wr_arbiter #(
    parameter int DW    = 8,
    parameter int BURST = 16,
    parameter int CW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    fifo_wr_arbiter_if.slave   bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(BURST - 1);

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ptr_q, ptr_d;

    logic          owner1;
    logic          req_g;
    logic          pick1;
    logic          wr_en;
    logic          ack0_c;
    logic          ack1_c;
    logic [DW-1:0] data_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        pick1   = 1'b0;
        wr_en   = 1'b0;
        ack0_c  = 1'b0;
        ack1_c  = 1'b0;
        data_c  = '0;

        owner1 = grant_q[1];
        req_g  = owner1 ? bus.req1 : bus.req0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req0 | bus.req1) begin
                    pick1   = (bus.req0 & bus.req1) ? ptr_q : bus.req1;
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    cnt_d   = '0;
                    state_d = ST_BURST;
                end
            end

            ST_BURST: begin
                // reset gates the write itself so a mid-burst reset never leaks a word
                wr_en  = req_g & ~bus.wrfull & ~rst;
                ack0_c = wr_en & ~owner1;
                ack1_c = wr_en & owner1;
                if (wr_en) begin
                    data_c = owner1 ? bus.data1 : bus.data0;
                end

                if (!req_g) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                    ptr_d   = ~owner1;
                end else if (!bus.wrfull) begin
                    if (cnt_q == LAST) begin
                        state_d = ST_IDLE;
                        grant_d = 2'b00;
                        ptr_d   = ~owner1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    assign bus.wrreq = wr_en;
    assign bus.ack0  = ack0_c;
    assign bus.ack1  = ack1_c;
    assign bus.data  = data_c;
    assign bus.grant = grant_q;
    assign bus.busy  = (state_q == ST_BURST);

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the 8-bit FIFO between two data sources (for example two wr-side generators).
- Grants the port in round-robin bursts of up to BURST words and honours wrfull so no write is attempted into a full FIFO.
- Sits between the source blocks and the FIFO write side.
- Replaces direct wiring of one generator's data/wrreq to the FIFO.

Parameters:
- DW, 8: data width of sources and FIFO.
- BURST, 16: maximum words written per grant. Range 1..255.
- CW, 8: width of the internal burst counter. Must hold BURST-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  source 0 has a valid word on data0.
- data0  in  DW  source 0 word.
- ack0  out  1  source 0 word consumed this cycle.
- req1  in  1  source 1 has a valid word on data1.
- data1  in  DW  source 1 word.
- ack1  out  1  source 1 word consumed this cycle.
- wrfull  in  1  FIFO full flag.
- wrreq  out  1  FIFO write enable.
- data  out  DW  FIFO write data.
- grant  out  2  one-hot registered owner (01 = src0, 10 = src1, 00 = none).
- busy  out  1  high while in the BURST state.

Behaviour:
- Reset (rst sampled high):
  - Next state is IDLE; grant=00; cnt=0; ptr=0 (src0 preferred).
  - wrreq, ack0 and ack1 are forced 0 combinationally in every cycle rst is high, including a reset asserted mid-burst.
  - data=0 whenever wrreq=0.
- States: IDLE, BURST. busy = (state==BURST).
- IDLE:
  - Neither req high: stay in IDLE, grant=00.
  - Only reqk high: grant<=k, go to BURST, cnt<=0.
  - Both req high: grant<=ptr, go to BURST, cnt<=0.
  - No writes occur in IDLE. There is always a one-cycle bubble between bursts.
- BURST, owner g:
  - Combinational write: wrreq = req_g & ~wrfull & ~rst.
  - Combinational data and ack: data = data_g, ack_g = wrreq, ack of the non-owner = 0.
  - Source handshake: a word is consumed in the cycle ack is high. The source must hold data_g stable while req_g is high and ack_g is low.
  - Write with cnt==BURST-1: burst complete. Go to IDLE, grant<=00, ptr<=~g, cnt<=0.
  - Write with cnt<BURST-1: cnt<=cnt+1, stay in BURST.
  - req_g low: release. Go to IDLE, grant<=00, ptr<=~g, cnt unchanged until the next grant. A release counts as a completed turn.
  - wrfull high with req_g high: stall. No write, cnt holds, grant holds. There is no timeout; the owner keeps the port until it drains or releases.
- Request changes: the non-owner's req is ignored during BURST. Owner req dropping in the same cycle wrfull rises takes the release path.
- Zero latency: wrreq/data/ack are combinational from state and inputs, so wrfull is never violated by a registered overshoot.
- Width rules: cnt compares against BURST-1 in CW bits. data passes through unmodified; no arithmetic on data.
- Fairness: with both sources continuously requesting and the FIFO never full, the grant pattern is src0 BURST words, bubble, src1 BURST words, bubble, and so on.

Test Plan:
- Reset, then req0=1 with data0 counting 0,1,2..., req1=0, wrfull=0:
  - grant=01 one cycle after reset release.
  - 16 writes of data 0..15, then one IDLE bubble, then grant=01 again with data 16..
- req0=req1=1 continuously, wrfull=0:
  - Bursts alternate 01,10,01.
  - Each burst has exactly 16 wrreq pulses.
  - ack0 and ack1 are never high together.
  - One bubble between bursts.
- Source 0 mid-burst, wrfull forced high for 5 cycles after the 6th write:
  - wrreq=0 and ack0=0 for those 5 cycles, grant stays 01.
  - Writes resume at word 6; burst ends after 16 total writes.
- req0 drops after 3 words while req1=1:
  - Next cycle is IDLE.
  - Following cycle grant=10 and src1 is written.
  - Source 0 got exactly 3 acks.
- rst pulsed high for 1 cycle mid-burst of source 1:
  - wrreq=0 and ack1=0 in the rst cycle.
  - Next cycle state is IDLE, grant=00, ptr=0.
  - If both req are high, src0 is granted next.
- Scoreboard over 1000 random cycles of random req/wrfull:
  - No wrreq while wrfull=1.
  - FIFO contents equal the concatenation of acked words in ack order.
